// File: rtl/bcd_serial_adder.sv
// Packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Operands captured on a start/busy handshake; results presented with a done pulse.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          state_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_reg;
    logic            carry_reg;
    logic            inv_reg;
    logic [CW-1:0]   cnt_reg;

    logic [DIGITS-1:0] a_bad;
    logic [DIGITS-1:0] b_bad;
    logic [W-1:0]      b_cap;
    logic              inv_cap;

    // Subtraction is A + (9's complement of B) + 1, so B is complemented at capture.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign a_bad[gi]          = (A[4*gi +: 4] > 4'd9);
            assign b_bad[gi]          = (B[4*gi +: 4] > 4'd9);
            assign b_cap[4*gi +: 4]   = sub ? (4'd9 - B[4*gi +: 4]) : B[4*gi +: 4];
        end
    endgenerate

    assign inv_cap = (|a_bad) | (|b_bad);

    int unsigned  base;
    logic [3:0]   a_dig;
    logic [3:0]   b_dig;
    logic [4:0]   t;
    logic [4:0]   t_adj;
    logic [3:0]   dig;
    logic         carry_next;
    logic [W-1:0] res_next;
    logic         last;

    always_comb begin
        base       = 4 * int'(cnt_reg);
        a_dig      = a_reg[base +: 4];
        b_dig      = b_reg[base +: 4];
        t          = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_reg};
        t_adj      = t - 5'd10;
        if (t >= 5'd10) begin
            dig        = t_adj[3:0];
            carry_next = 1'b1;
        end else begin
            dig        = t[3:0];
            carry_next = 1'b0;
        end
        res_next          = res_reg;
        res_next[base +: 4] = dig;
        last              = (cnt_reg == CW'(DIGITS - 1));
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            inv_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= b_cap;
                        carry_reg <= sub | cin;
                        inv_reg   <= inv_cap;
                        cnt_reg   <= '0;
                        res_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last) begin
                        // Digit steps run regardless; a bad operand only masks the result.
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        invalid   <= inv_reg;
                        sum       <= inv_reg ? '0 : res_next;
                        cout      <= inv_reg ? 1'b0 : carry_next;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
